// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter sequencing a fixed-latency single-port memory; ports: i_* fetch side, d_* data side, mem_* memory command, stall_* pipeline stalls
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  output logic          i_valid,
  output logic          stall_i,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_d,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic last_d, cap_wr, ir, dr, grant, grant_d, done;
  always_comb begin
    ir = i_req & ~i_valid;
    dr = d_req & ~d_valid;
    grant = state == IDLE && (ir | dr);
    grant_d = dr & (~ir | ~last_d);
    done = cnt == CW'(LATENCY - 1);
    state_nx = state == IDLE ? (grant ? (grant_d ? BUSY_D : BUSY_I) : IDLE) : (done ? IDLE : state);
    mem_en = state != IDLE;
    mem_wr = mem_en & cap_wr;
    stall_i = i_req & ~i_valid;
    stall_d = d_req & ~d_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_d <= 1'b0;
      cap_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      i_data <= '0;
      d_rdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == IDLE || done) ? '0 : cnt + 1'b1;
      i_valid <= state == BUSY_I && done;
      d_valid <= state == BUSY_D && done;
      if (grant) begin
        last_d <= grant_d;
        mem_addr <= grant_d ? d_addr : i_addr;
        cap_wr <= grant_d & d_wr;
        if (grant_d) mem_wdata <= d_wdata;
      end
      if (state == BUSY_I && done) i_data <= mem_rdata;
      if (state == BUSY_D && done && !cap_wr) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;
  logic i_valid, d_valid, stall_i, stall_d, mem_en, mem_wr;
  int total = 0, bad = 0;
  logic iv, dv;
  always #5 clk = ~clk;
  mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .stall_i(stall_i),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .stall_d(stall_d),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc_start();
    @(posedge clk);
    #1;
    mem_rdata = 16'($urandom);
  endtask
  // Transaction-level model: side in flight (0 none, 1 I, 2 D), cycles left, captured command
  int ms, left;
  logic [15:0] ma, mwd, mid, mdr;
  logic mw, ml, miv, mdv, niv, ndv, mir, mdr_req, gd;
  always @(negedge clk) begin
    if (rst) begin
      ms = 0; left = 0; ma = '0; mwd = '0; mid = '0; mdr = '0;
      mw = 1'b0; ml = 1'b0; miv = 1'b0; mdv = 1'b0;
    end
    chk("m_mem_en", mem_en, ms != 0);
    chk("m_mem_wr", mem_wr, ms == 2 && mw);
    chk("m_mem_addr", mem_addr, ma);
    if (ms == 2 && mw) chk("m_mem_wdata", mem_wdata, mwd);
    chk("m_i_valid", i_valid, miv);
    chk("m_d_valid", d_valid, mdv);
    chk("m_i_data", i_data, mid);
    chk("m_d_rdata", d_rdata, mdr);
    chk("m_stall_i", stall_i, i_req && !miv);
    chk("m_stall_d", stall_d, d_req && !mdv);
    if (!rst) begin
      niv = 1'b0; ndv = 1'b0;
      if (ms != 0) begin
        if (left == 1) begin
          if (ms == 1) begin mid = mem_rdata; niv = 1'b1; end
          else begin if (!mw) mdr = mem_rdata; ndv = 1'b1; end
          ms = 0;
        end else left--;
      end else begin
        mir = i_req && !miv;
        mdr_req = d_req && !mdv;
        if (mir || mdr_req) begin
          gd = mdr_req && (!mir || !ml);
          ms = gd ? 2 : 1;
          left = L;
          ml = gd;
          ma = gd ? d_addr : i_addr;
          mw = gd && d_wr;
          if (gd) mwd = d_wdata;
        end
      end
      miv = niv; mdv = ndv;
    end
  end
  initial begin
    i_req = 1'b1;
    @(negedge clk);
    chk("rst_stall_i", stall_i, 1);
    chk("rst_stall_d", stall_d, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_data", i_data, 0);
    cyc_start(); i_req = 1'b0; rst = 1'b0;
    cyc_start(); i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc_start();
      if (c == 2) i_addr = 16'h0777;
      if (c == 4) mem_rdata = 16'hA5C3;
      @(negedge clk);
      chk("fetch_en", mem_en, c >= 1 && c <= 4);
      chk("fetch_stall", stall_i, c <= 4);
      chk("fetch_valid", i_valid, c == 5);
      if (c >= 1 && c <= 4) begin chk("fetch_addr", mem_addr, 16'h0010); chk("fetch_wr", mem_wr, 0); end
      if (c == 5) chk("fetch_data", i_data, 16'hA5C3);
    end
    for (int c = 0; c < 2; c++) begin
      cyc_start(); i_req = 1'b0;
      @(negedge clk);
      chk("held_no_dup", mem_en, 0);
    end
    cyc_start(); d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h8002; d_wdata = 16'h1234;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc_start();
      if (c == 2) d_wdata = 16'hFFFF;
      @(negedge clk);
      chk("wr_wr", mem_wr, c >= 1 && c <= 4);
      chk("wr_valid", d_valid, c == 5);
      chk("wr_rdata", d_rdata, 0);
      if (c >= 1 && c <= 4) begin chk("wr_wdata", mem_wdata, 16'h1234); chk("wr_addr", mem_addr, 16'h8002); end
    end
    cyc_start(); d_req = 1'b0; rst = 1'b1;
    cyc_start(); rst = 1'b0;
    cyc_start(); i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) cyc_start();
      if (c == 4) mem_rdata = 16'h1111;
      if (c == 9) mem_rdata = 16'h2222;
      if (c == 6) d_req = 1'b0;
      @(negedge clk);
      chk("tie_en", mem_en, (c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      if (c >= 1 && c <= 4) chk("tie_d_addr", mem_addr, 16'h0200);
      if (c >= 6 && c <= 9) chk("tie_i_addr", mem_addr, 16'h0100);
      chk("tie_d_valid", d_valid, c == 5);
      chk("tie_i_valid", i_valid, c == 10);
      chk("tie_stall_i", stall_i, c <= 9);
      if (c == 5) chk("tie_d_rdata", d_rdata, 16'h1111);
      if (c == 10) chk("tie_i_data", i_data, 16'h2222);
    end
    cyc_start(); i_addr = 16'h0300; d_addr = 16'h0400; d_req = 1'b1;
    cyc_start();
    @(negedge clk);
    chk("tie2_d_first", mem_addr, 16'h0400);
    for (int k = 0; k < 30; k++) begin
      iv = i_valid; dv = d_valid;
      cyc_start();
      if (iv) i_req = 1'b0;
      if (dv) d_req = 1'b0;
      @(negedge clk);
    end
    chk("drain_done", {i_req, d_req}, 0);
    cyc_start(); d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
    repeat (3) cyc_start();
    chk("abort_en_before", mem_en, 1);
    #2 rst = 1'b1;
    #1 chk("abort_en_async", mem_en, 0);
    d_req = 1'b0;
    cyc_start(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_dv", d_valid, 0);
      chk("abort_idle", mem_en, 0);
      cyc_start();
    end
    i_req = 1'b1; i_addr = 16'h0055;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc_start();
      @(negedge clk);
      chk("post_rst_en", mem_en, c >= 1 && c <= 4);
      chk("post_rst_valid", i_valid, c == 5);
    end
    cyc_start(); i_req = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      iv = i_valid; dv = d_valid;
      cyc_start();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) begin rst = 1'b1; i_req = 1'b0; d_req = 1'b0; end
      if (!rst) begin
        if (!i_req || iv) begin
          i_req = $urandom_range(0, 2) == 0;
          i_addr = 16'($urandom);
        end
        if (!d_req || dv) begin
          d_req = $urandom_range(0, 2) == 0;
          d_wr = 1'($urandom);
          d_addr = 16'($urandom);
          d_wdata = 16'($urandom);
        end
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
